// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register busy scoreboard and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  claim_en,
    input  logic [AW-1:0]         claim_addr
);

    localparam logic [0:0]    ST_INIT  = 1'b0;
    localparam logic [0:0]    ST_READY = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
    localparam bit            ZR       = (ZERO_REG != 0);

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic            ready_s;
    logic            wr_ok_s;
    logic            claim_ok_s;
    logic            we_s;
    logic [AW-1:0]   waddr_s;
    logic [XLEN-1:0] wdata_s;

    assign ready_s   = (state_q == ST_READY);
    assign init_done = ready_s;

    // Qualify writeback and claims: ignored during the sweep and dropped for a hardwired x0.
    always_comb begin
        wr_ok_s    = ready_s && wr_en    && !(ZR && (wr_addr    == ZERO_IDX));
        claim_ok_s = ready_s && claim_en && !(ZR && (claim_addr == ZERO_IDX));
    end

    // Sweep sequencing and single storage write port selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        waddr_s = wr_addr;
        wdata_s = wr_data;
        case (state_q)
            ST_INIT: begin
                we_s    = 1'b1;
                waddr_s = cnt_q;
                wdata_s = {XLEN{1'b0}};
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_READY: begin
                we_s = wr_ok_s;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = ZERO_IDX;
            end
        endcase
    end

    // Scoreboard: writeback clears, claim sets afterwards so a same-cycle claim wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok_s) begin
            busy_d[wr_addr] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (claim_ok_s) begin
            busy_d[claim_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
    end

    // Control state with asynchronous reset; a reset mid-sweep restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= ZERO_IDX;
            busy_q  <= {NREGS{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is left unreset so it can map onto a RAM-like array; the sweep clears it.
    always_ff @(posedge clk) begin
        if (we_s) begin
            regs_q[waddr_s] <= wdata_s;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        rd_busy = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            if (!ready_s || (ZR && (a == ZERO_IDX))) begin
                rd_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy[k]              = 1'b0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_ok_s && (wr_addr == a)) begin
                rd_data[k*XLEN +: XLEN] = wr_data;
                rd_busy[k]              = claim_ok_s && (claim_addr == a);
`endif
            end else begin
                rd_data[k*XLEN +: XLEN] = regs_q[a];
                rd_busy[k]              = busy_q[a];
            end
        end
    end

endmodule
